// File: rtl/tile_ingress_port.sv
// Tile ingress port: buffers transfers arriving from one side of the tile,
// resolves each transfer's XY route on entry, and offers the head entry to
// the one target fifo_arb selected by that route.

package tile_pkg;

    // Side of a tile; the value doubles as the bit index into per-target vectors.
    typedef enum logic [2:0] {
        NORTH = 3'd0,
        EAST  = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } t_cardinal;

    // Transaction moved between tiles; address[31:24] carries the target tile ID.
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        t_cardinal   next_tile_fifo_arb_id;
    } t_tile_trans;

endpackage

module tile_ingress_port
    import tile_pkg::*;
#(
    parameter t_cardinal   IN_DIR    = NORTH,
    parameter int unsigned ING_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  local_tile_id,
    input  logic        in_req_valid,
    input  t_tile_trans in_req,
    output logic        out_ready_in,
    input  logic [4:0]  out_ready_fifo,
    output logic [4:0]  valid_alloc_req,
    output t_tile_trans alloc_req,
    output logic [15:0] fwd_count,
    output logic        err_overflow,
    output logic        err_uturn
);

    localparam int unsigned PW = $clog2(ING_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(ING_DEPTH);

    // Dimension-ordered routing: settle X first, then Y, else deliver locally.
    function automatic t_cardinal route_xy(input logic [7:0] target_id,
                                           input logic [7:0] local_id);
        t_cardinal dir;
        if (target_id[3:0] > local_id[3:0]) begin
            dir = EAST;
        end else if (target_id[3:0] < local_id[3:0]) begin
            dir = WEST;
        end else if (target_id[7:4] > local_id[7:4]) begin
            dir = NORTH;
        end else if (target_id[7:4] < local_id[7:4]) begin
            dir = SOUTH;
        end else begin
            dir = LOCAL;
        end
        return dir;
    endfunction

    // Storage is never reset: every output that exposes it is gated by count.
    t_tile_trans mem_q [ING_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   fwd_count_q, fwd_count_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_uturn_q, err_uturn_d;

    t_tile_trans   head;
    t_tile_trans   push_entry;
    t_cardinal     routed_dir;
    logic          empty;
    logic          push;
    logic          pop;

    // Head presentation and handshakes; ready is a pure function of count.
    always_comb begin
        head         = mem_q[rd_ptr_q];
        empty        = (count_q == '0);
        out_ready_in = (count_q < DEPTH_C);
        push         = in_req_valid && out_ready_in;

        routed_dir = route_xy(in_req.address[31:24], local_tile_id);
        push_entry = in_req;
        push_entry.next_tile_fifo_arb_id = routed_dir;

        valid_alloc_req = '0;
        for (int d = 0; d < 5; d++) begin
            valid_alloc_req[d] = !empty
                && (head.next_tile_fifo_arb_id == t_cardinal'(d[2:0]))
                && out_ready_fifo[d];
        end

        alloc_req = empty ? '0 : head;
        pop       = |valid_alloc_req;
    end

    // Next-state for pointers, occupancy, forwarded count and sticky errors.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        fwd_count_d    = fwd_count_q;
        err_overflow_d = err_overflow_q;
        err_uturn_d    = err_uturn_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (fwd_count_q != 16'hFFFF) begin
                fwd_count_d = fwd_count_q + 16'd1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A push offered while full is dropped; only the flag records it.
        if (in_req_valid && !out_ready_in) begin
            err_overflow_d = 1'b1;
        end
        // A route back out of the arrival side is flagged but still forwarded.
        if (push && (routed_dir == IN_DIR) && (IN_DIR != LOCAL)) begin
            err_uturn_d = 1'b1;
        end
    end

    // Control state, cleared asynchronously so outputs drop within the reset cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            fwd_count_q    <= '0;
            err_overflow_q <= 1'b0;
            err_uturn_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            fwd_count_q    <= fwd_count_d;
            err_overflow_q <= err_overflow_d;
            err_uturn_q    <= err_uturn_d;
        end
    end

    // Entry write with the routed direction already folded in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign fwd_count    = fwd_count_q;
    assign err_overflow = err_overflow_q;
    assign err_uturn    = err_uturn_q;

endmodule

// File: tb/tb_tile_ingress_port.sv
// Bench for tile_ingress_port: two instances (arrival side WEST and EAST)
// share stimulus; a queue-based model predicts every output each cycle.
module tb_tile_ingress_port;
    import tile_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [7:0]  local_id;
    logic        in_v;
    t_tile_trans in_r;
    logic [4:0]  in_rdy;

    logic        rw, re, ow, oe, uw, ue;
    logic [4:0]  vw, ve;
    t_tile_trans aw, ae;
    logic [15:0] fw, fe;

    tile_ingress_port #(.IN_DIR(WEST), .ING_DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst(rst), .local_tile_id(local_id), .in_req_valid(in_v),
        .in_req(in_r), .out_ready_in(rw), .out_ready_fifo(in_rdy),
        .valid_alloc_req(vw), .alloc_req(aw), .fwd_count(fw),
        .err_overflow(ow), .err_uturn(uw));

    tile_ingress_port #(.IN_DIR(EAST), .ING_DEPTH(DEPTH)) dut_e (
        .clk(clk), .rst(rst), .local_tile_id(local_id), .in_req_valid(in_v),
        .in_req(in_r), .out_ready_in(re), .out_ready_fifo(in_rdy),
        .valid_alloc_req(ve), .alloc_req(ae), .fwd_count(fe),
        .err_overflow(oe), .err_uturn(ue));

    logic [90:0] obs_w, obs_e;
    assign obs_w = {vw, aw, rw, fw, ow, uw};
    assign obs_e = {ve, ae, re, fe, oe, ue};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    t_tile_trans q[$];
    int          fwd_m;
    bit          ovf_m, ut_w_m, ut_e_m;

    function automatic t_cardinal ref_route(input logic [7:0] t, input logic [7:0] l);
        int tx = int'(t[3:0]);
        int ty = int'(t[7:4]);
        int lx = int'(l[3:0]);
        int ly = int'(l[7:4]);
        if (tx > lx) return EAST;
        if (tx < lx) return WEST;
        if (ty > ly) return NORTH;
        if (ty < ly) return SOUTH;
        return LOCAL;
    endfunction

    function automatic logic [90:0] exp_vec(input bit east);
        logic [4:0]  v = '0;
        t_tile_trans a = '0;
        if (q.size() > 0) begin
            a = q[0];
            if (in_rdy[int'(a.next_tile_fifo_arb_id)]) v[int'(a.next_tile_fifo_arb_id)] = 1'b1;
        end
        return {v, a, 1'(q.size() < DEPTH), 16'(fwd_m), ovf_m, east ? ut_e_m : ut_w_m};
    endfunction

    task automatic model_reset();
        q.delete();
        fwd_m  = 0;
        ovf_m  = 0;
        ut_w_m = 0;
        ut_e_m = 0;
    endtask

    task automatic model_tick();
        bit          can = (q.size() < DEPTH);
        t_tile_trans e;
        if (q.size() > 0 && in_rdy[int'(q[0].next_tile_fifo_arb_id)]) begin
            void'(q.pop_front());
            if (fwd_m < 65535) fwd_m++;
        end
        if (in_v && !can) ovf_m = 1;
        if (in_v && can) begin
            e = in_r;
            e.next_tile_fifo_arb_id = ref_route(in_r.address[31:24], local_id);
            q.push_back(e);
            if (e.next_tile_fifo_arb_id == WEST) ut_w_m = 1;
            if (e.next_tile_fifo_arb_id == EAST) ut_e_m = 1;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rdy);
        logic [2:0] r3 = 3'($urandom_range(0, 4));
        in_v    = v;
        in_r.address = addr;
        in_r.data    = data;
        in_r.next_tile_fifo_arb_id = t_cardinal'(r3);
        in_rdy  = rdy;
        #1;
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] lid);
        rst      = 1'b0;
        in_v     = 1'b0;
        in_rdy   = '0;
        local_id = lid;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        in_v = 1'b0; in_r = '0; in_rdy = 5'h1F; local_id = 8'h11;
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_w !== exp_vec(0)) begin
            errors++; $display("FAIL reset_w got=%h exp=%h", obs_w, exp_vec(0));
        end
        checks++;
        if (vw !== 5'b0 || aw !== '0 || rw !== 1'b1 || fw !== 16'd0 || ow !== 1'b0 || uw !== 1'b0) begin
            errors++; $display("FAIL reset_values got=%h", obs_w);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_east_route();
        do_reset(8'h11);
        drive(1'b1, 32'h13AB_CDEF, 32'hA5A5_0001, 5'h1F);
        checks++;
        if (obs_w !== exp_vec(0)) begin
            errors++; $display("FAIL east_push got=%h exp=%h", obs_w, exp_vec(0));
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (vw !== 5'b00010 || aw.next_tile_fifo_arb_id !== EAST || aw.data !== 32'hA5A5_0001) begin
            errors++; $display("FAIL east_fwd valid=%b dir=%0d exp valid=00010 dir=1", vw, aw.next_tile_fifo_arb_id);
        end
        checks++;
        if (obs_w !== exp_vec(0)) begin
            errors++; $display("FAIL east_model got=%h exp=%h", obs_w, exp_vec(0));
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (fw !== 16'd1 || vw !== 5'b0 || uw !== 1'b0) begin
            errors++; $display("FAIL east_count fwd=%0d valid=%b uturn=%b exp 1/00000/0", fw, vw, uw);
        end
    endtask

    task automatic test_local_stall();
        do_reset(8'h22);
        drive(1'b1, 32'h2200_0040, 32'h0000_BEEF, 5'h0F);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 5'h0F);
            checks++;
            if (vw !== 5'b0 || obs_w !== exp_vec(0)) begin
                errors++; $display("FAIL local_stall%0d valid=%b exp=00000", i, vw);
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (vw !== 5'b10000 || obs_w !== exp_vec(0)) begin
            errors++; $display("FAIL local_release valid=%b exp=10000", vw);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (vw !== 5'b0 || fw !== 16'd1) begin
            errors++; $display("FAIL local_single valid=%b fwd=%0d exp 00000/1", vw, fw);
        end
    endtask

    task automatic test_overflow();
        do_reset(8'h11);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {8'h11 + 8'(i), 24'h0}, 32'(i), 5'h00);
            checks++;
            if (rw !== (i < 2) || obs_w !== exp_vec(0)) begin
                errors++; $display("FAIL ovf_ready%0d got=%b exp=%b", i, rw, (i < 2));
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 5'h00);
        checks++;
        if (ow !== 1'b1 || rw !== 1'b0) begin
            errors++; $display("FAIL ovf_flag err=%b ready=%b exp 1/0", ow, rw);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 5'h1F);
            checks++;
            if (obs_w !== exp_vec(0)) begin
                errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, obs_w, exp_vec(0));
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (fw !== 16'd2 || ow !== 1'b1) begin
            errors++; $display("FAIL ovf_entries fwd=%0d err=%b exp 2/1", fw, ow);
        end
    endtask

    task automatic test_uturn();
        do_reset(8'h11);
        drive(1'b1, 32'h1500_0000, 32'h0000_0015, 5'h1F);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (ue !== 1'b1 || ve !== 5'b00010 || uw !== 1'b0) begin
            errors++; $display("FAIL uturn east_err=%b east_valid=%b west_err=%b exp 1/00010/0", ue, ve, uw);
        end
        checks++;
        if (obs_e !== exp_vec(1)) begin
            errors++; $display("FAIL uturn_model got=%h exp=%h", obs_e, exp_vec(1));
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (ue !== 1'b1 || fe !== 16'd1) begin
            errors++; $display("FAIL uturn_sticky err=%b fwd=%0d exp 1/1", ue, fe);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        int          n = 0;
        logic [4:0]  rdy;
        do_reset(8'h11);
        for (int cyc = 0; cyc < 40; cyc++) begin
            logic [31:0] d = $urandom;
            logic        v = (n < 8) && (q.size() < DEPTH);
            rdy = (cyc < 2) ? 5'h00 : 5'h1F;
            drive(v, {8'h10 + 8'(n % 4), 24'h0}, d, rdy);
            checks++;
            if (obs_w !== exp_vec(0)) begin
                errors++; $display("FAIL b2b_cyc%0d got=%h exp=%h", cyc, obs_w, exp_vec(0));
            end
            if (vw !== 5'b0) got.push_back(aw.data);
            if (v) begin sent.push_back(d); n++; end
            tick();
        end
        checks++;
        if (got.size() != 8) begin
            errors++; $display("FAIL b2b_count got=%0d exp=8", got.size());
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
                errors++; $display("FAIL b2b_order%0d got=%h exp=%h", i, got[i], sent[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) do_reset(8'($urandom));
            drive(1'($urandom_range(0, 9) < 7), $urandom, $urandom, 5'($urandom));
            checks++;
            if (obs_w !== exp_vec(0)) begin
                errors++; $display("FAIL rand_w%0d got=%h exp=%h", i, obs_w, exp_vec(0));
            end
            checks++;
            if (obs_e !== exp_vec(1)) begin
                errors++; $display("FAIL rand_e%0d got=%h exp=%h", i, obs_e, exp_vec(1));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(8'h11);
        drive(1'b1, 32'h1300_0000, 32'h1, 5'h00);
        tick();
        drive(1'b1, 32'h1100_0000, 32'h2, 5'h00);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (vw !== 5'b00010) begin
            errors++; $display("FAIL rstmid_pre valid=%b exp=00010", vw);
        end
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_w !== exp_vec(0) || obs_e !== exp_vec(1) || rw !== 1'b1 || vw !== 5'b0) begin
            errors++; $display("FAIL rstmid_async got=%h exp=%h", obs_w, exp_vec(0));
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 5'h1F);
            checks++;
            if (vw !== 5'b0 || rw !== 1'b1 || obs_w !== exp_vec(0)) begin
                errors++; $display("FAIL rstmid_after%0d valid=%b ready=%b exp 00000/1", i, vw, rw);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset(8'h00);
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 32'h0, 32'(i), 5'h1F);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 5'h1F);
        checks++;
        if (fw !== 16'hFFFF) begin
            errors++; $display("FAIL fwd_saturate got=%h exp=FFFF", fw);
        end
        checks++;
        if (obs_w !== exp_vec(0)) begin
            errors++; $display("FAIL sat_model got=%h exp=%h", obs_w, exp_vec(0));
        end
    endtask

    initial begin
        test_reset();
        test_east_route();
        test_local_stall();
        test_overflow();
        test_uturn();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_ingress_port.md
TILE_INGRESS_PORT -- requirements
Module: tile_ingress_port

Interface
REQ-001 The block SHALL have parameter IN_DIR, default NORTH (t_cardinal): the side of the tile this port receives from.
REQ-002 The block SHALL have parameter ING_DEPTH, default 2: buffer entries, power of two, minimum 2.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port local_tile_id, input, 8: this tile's ID; [3:0] = x, [7:4] = y; quasi-static.
REQ-006 The block SHALL have port in_req_valid, input, 1: upstream winner_req_valid; a committed transfer.
REQ-007 The block SHALL have port in_req, input, t_tile_trans: upstream winner_req.
REQ-008 The block SHALL have port out_ready_in, output, 1: to upstream in_ready_<IN_DIR>_arb_fifo; 1 = space for one transfer this cycle.
REQ-009 The block SHALL have port out_ready_fifo, input, 5: per-target fifo_arb ready; index 0..4 = NORTH, EAST, SOUTH, WEST, LOCAL.
REQ-010 The block SHALL have port valid_alloc_req, output, 5: per-target push, same indexing.
REQ-011 The block SHALL have port alloc_req, output, t_tile_trans: shared data to all five targets.
REQ-012 The block SHALL have port fwd_count, output, 16: saturating count of forwarded transactions.
REQ-013 The block SHALL have port err_overflow, output, 1: sticky; set on push while full.
REQ-014 The block SHALL have port err_uturn, output, 1: sticky; set when a route resolves to IN_DIR.

Function
REQ-015 Target tile ID SHALL be in_req.address[31:24]: tx = [27:24], ty = [31:28].
REQ-016 Routing SHALL be XY and computed at push time:
- tx > lx -> EAST; tx < lx -> WEST.
- otherwise ty > ly -> NORTH; ty < ly -> SOUTH.
- otherwise LOCAL.
REQ-017 The stored entry SHALL hold the transaction with next_tile_fifo_arb_id overwritten by the routed direction D.
REQ-018 The buffer SHALL be a circular FIFO of ING_DEPTH entries with wr_ptr, rd_ptr and a count of width clog2(ING_DEPTH)+1.
REQ-019 out_ready_in SHALL equal (count < ING_DEPTH) and SHALL depend only on registered state, never on in_req_valid or out_ready_fifo.
REQ-020 Push SHALL occur when in_req_valid && out_ready_in; the entry is visible at the head the next cycle, giving a minimum latency of 1 cycle.
REQ-021 valid_alloc_req[d] SHALL be 1 iff count != 0 && head.D == d && out_ready_fifo[d]; at most one bit is set per cycle.
REQ-022 alloc_req SHALL be the head entry whenever count != 0, and all zeros when empty.
REQ-023 Pop SHALL occur iff |valid_alloc_req; a stalled head blocks later entries (no reordering, head-of-line blocking accepted).
REQ-024 A simultaneous push and pop SHALL leave count unchanged, and both pointers SHALL advance.
REQ-025 Pointers SHALL wrap modulo ING_DEPTH.
REQ-026 Push with in_req_valid while full SHALL drop the data, leave state unchanged, and set err_overflow.
REQ-027 If a pushed transaction routes to D == IN_DIR and IN_DIR != LOCAL, err_uturn SHALL be set; the transaction is still buffered and forwarded normally.
REQ-028 fwd_count SHALL increment by 1 per pop and saturate at 16'hFFFF.
REQ-029 Sticky errors SHALL clear only on reset.

Reset
REQ-030 On rst = 0, asynchronously: count, pointers, fwd_count, err_overflow, err_uturn = 0; valid_alloc_req = 0; alloc_req = 0; out_ready_in = 1 (ING_DEPTH > 0).
REQ-031 Reset mid-transfer SHALL discard buffered entries, with no output pulse during or after reset.
REQ-032 Buffer data storage SHALL need no reset; outputs are gated by count.

Verification
REQ-033 Local 0x11, IN_DIR = WEST, push tx = 3, ty = 1, all readies = 1 -> next cycle valid_alloc_req = 5'b00010 (EAST), next_tile_fifo_arb_id = EAST, fwd_count = 1.
REQ-034 Local 0x22, push target 0x22 with out_ready_fifo[LOCAL] = 0 for 3 cycles, then 1 -> valid_alloc_req stays 0, then a LOCAL pulse of exactly 1 cycle.
REQ-035 ING_DEPTH = 2, all readies = 0, three back-to-back pushes -> out_ready_in = 0 after the second push, third push dropped, err_overflow = 1, count = 2.
REQ-036 Full buffer, push plus pop in the same cycle (upstream violating out_ready_in excluded) -> count stays 2, order preserved across the pointer wrap over 8 transactions.
REQ-037 IN_DIR = EAST, local 0x11, push target 0x15 -> EAST forwarded, err_uturn = 1.
REQ-038 Assert rst with 2 entries buffered -> all outputs at reset values within the same cycle, no valid_alloc_req after release, out_ready_in = 1.
